// File: rtl/music_sequencer_pkg.sv
// Shared constants for the music sequencer: note frequencies, octave codes,
// tempo selections and the player state enumeration.
package music_pkg;

  // Player states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // tempo_sel encodings
  localparam logic [1:0] TEMPO_X1     = 2'b00;
  localparam logic [1:0] TEMPO_X2     = 2'b01;
  localparam logic [1:0] TEMPO_HALF   = 2'b10;
  localparam logic [1:0] TEMPO_X1_ALT = 2'b11;

  // Octave field of a ROM entry
  localparam logic [1:0] OCT_BASE = 2'd0;
  localparam logic [1:0] OCT_UP   = 2'd1;
  localparam logic [1:0] OCT_DOWN = 2'd2;

  // Chromatic note indices (values above N_B are rests)
  localparam logic [3:0] N_C = 4'd0, N_CS = 4'd1, N_D = 4'd2, N_DS = 4'd3;
  localparam logic [3:0] N_E = 4'd4, N_F = 4'd5, N_FS = 4'd6, N_G = 4'd7;
  localparam logic [3:0] N_GS = 4'd8, N_A = 4'd9, N_AS = 4'd10, N_B = 4'd11;
  localparam logic [3:0] N_REST = 4'd12;

  // Base-octave frequencies in Hz and the out-of-audio-band silence code
  localparam logic [31:0] HZ_C = 32'd261, HZ_CS = 32'd277, HZ_D = 32'd293, HZ_DS = 32'd311;
  localparam logic [31:0] HZ_E = 32'd329, HZ_F = 32'd349, HZ_FS = 32'd369, HZ_G = 32'd392;
  localparam logic [31:0] HZ_GS = 32'd415, HZ_A = 32'd440, HZ_AS = 32'd466, HZ_B = 32'd493;
  localparam logic [31:0] SILENCE_HZ = 32'd20000;

  // Decode a 6-bit ROM entry {octave, note} into a frequency in Hz
  function automatic logic [31:0] note_to_hz(input logic [5:0] code);
    logic [31:0] base;
    logic [31:0] hz;
    case (code[3:0])
      N_C:     base = HZ_C;
      N_CS:    base = HZ_CS;
      N_D:     base = HZ_D;
      N_DS:    base = HZ_DS;
      N_E:     base = HZ_E;
      N_F:     base = HZ_F;
      N_FS:    base = HZ_FS;
      N_G:     base = HZ_G;
      N_GS:    base = HZ_GS;
      N_A:     base = HZ_A;
      N_AS:    base = HZ_AS;
      N_B:     base = HZ_B;
      default: base = SILENCE_HZ;
    endcase
    case (code[5:4])
      OCT_BASE: hz = base;
      OCT_UP:   hz = base << 1;
      OCT_DOWN: hz = base >> 1;
      default:  hz = SILENCE_HZ;
    endcase
    if (base == SILENCE_HZ) hz = SILENCE_HZ;
    return hz;
  endfunction

endpackage

// File: rtl/music_sequencer_song_rom.sv
// Combinational song table: channel 0 carries a 16-beat melody, channel 1 a
// bass line changing every two beats. Beats past the song end are silent.
module song_rom
  import music_pkg::*;
#(
  parameter int SONG_LEN = 108
) (
  input  logic [7:0]  ch,
  input  logic [7:0]  beat,
  output logic [31:0] freq
);

  logic [5:0] code;

  // Select the note entry for this channel and beat, then decode it
  always_comb begin
    code = {OCT_BASE, N_REST};
    if (ch == 8'd0) begin
      case (beat[3:0])
        4'd0:  code = {OCT_BASE, N_C};
        4'd1:  code = {OCT_BASE, N_E};
        4'd2:  code = {OCT_BASE, N_G};
        4'd3:  code = {OCT_UP,   N_C};
        4'd4:  code = {OCT_BASE, N_B};
        4'd5:  code = {OCT_BASE, N_G};
        4'd6:  code = {OCT_BASE, N_A};
        4'd7:  code = {OCT_BASE, N_REST};
        4'd8:  code = {OCT_BASE, N_F};
        4'd9:  code = {OCT_BASE, N_A};
        4'd10: code = {OCT_UP,   N_C};
        4'd11: code = {OCT_BASE, N_A};
        4'd12: code = {OCT_BASE, N_G};
        4'd13: code = {OCT_BASE, N_E};
        4'd14: code = {OCT_BASE, N_D};
        4'd15: code = {OCT_BASE, N_C};
      endcase
    end else if (ch == 8'd1) begin
      case (beat[3:1])
        3'd0: code = {OCT_DOWN, N_C};
        3'd1: code = {OCT_DOWN, N_G};
        3'd2: code = {OCT_DOWN, N_A};
        3'd3: code = {OCT_DOWN, N_E};
        3'd4: code = {OCT_DOWN, N_F};
        3'd5: code = {OCT_DOWN, N_C};
        3'd6: code = {OCT_DOWN, N_G};
        3'd7: code = {OCT_DOWN, N_C};
      endcase
    end
    if (int'(beat) >= SONG_LEN) freq = SILENCE_HZ;
    else freq = note_to_hz(code);
  end

endmodule

// File: rtl/music_sequencer.sv
// Beat sequencer: steps through the song ROM at a tempo-scaled tick rate,
// with play/pause/stop control, optional looping and per-channel muting.
module music_sequencer
  import music_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int BEATS_PER_SEC = 8,
  parameter int SONG_LEN      = 108,
  parameter int NUM_CH        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  play,
  input  logic                  pause,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [1:0]            tempo_sel,
  input  logic [NUM_CH-1:0]     ch_mute,
  output logic [7:0]            beat_num,
  output logic [32*NUM_CH-1:0]  tone,
  output logic                  playing,
  output logic                  done
);

  localparam int BASE_P = CLK_HZ / BEATS_PER_SEC;
  localparam int FAST_P = (BASE_P / 2 > 0) ? BASE_P / 2 : 1;
  localparam int SLOW_P = BASE_P * 2;
  localparam logic [7:0] LAST_BEAT = 8'(SONG_LEN - 1);

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg;
  logic [7:0]  beat_reg;
  logic [1:0]  tempo_reg;
  logic        playing_reg;
  logic        done_reg;
  logic [31:0] period;
  logic        advance;
  logic        tick;
  logic        last_beat;
  logic        finish;

  // Beat length for the tempo latched at the last beat boundary
  always_comb begin
    case (tempo_reg)
      TEMPO_X1, TEMPO_X1_ALT: period = 32'(BASE_P);
      TEMPO_X2:               period = 32'(FAST_P);
      TEMPO_HALF:             period = 32'(SLOW_P);
      default:                period = 32'(BASE_P);
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; stop beats pause beats play
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (play && !pause && !stop) state_next = ST_PLAY;
      ST_PLAY: begin
        if (stop)                       state_next = ST_IDLE;
        else if (pause)                 state_next = ST_PAUSE;
        else if (finish)                state_next = ST_IDLE;
      end
      ST_PAUSE: begin
        if (stop)                       state_next = ST_IDLE;
        else if (!pause && play)        state_next = ST_PLAY;
      end
      default:                          state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: counter advance, beat tick and one-shot completion
  always_comb begin
    advance   = (state_reg == ST_PLAY) && !stop && !pause;
    last_beat = (beat_reg == LAST_BEAT);
    tick      = advance && (cnt_reg == period - 32'd1);
    finish    = tick && last_beat && !loop_en;
  end

  // Tick counter, beat index, tempo latch and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      beat_reg    <= '0;
      tempo_reg   <= TEMPO_X1;
      playing_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg    <= finish;
      playing_reg <= (state_next == ST_PLAY);
      if (state_next == ST_IDLE) begin
        cnt_reg  <= '0;
        beat_reg <= '0;
      end else if (tick) begin
        cnt_reg  <= '0;
        beat_reg <= last_beat ? 8'd0 : beat_reg + 8'd1;
      end else if (advance) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
      // Tempo only changes while idle or exactly at a beat boundary
      if (state_reg == ST_IDLE || tick) tempo_reg <= tempo_sel;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [31:0] rom_hz;
      logic [31:0] tone_ch_reg;

      song_rom #(.SONG_LEN(SONG_LEN)) u_rom (
        .ch   (8'(gi)),
        .beat (beat_reg),
        .freq (rom_hz)
      );

      // Register the channel note, silencing it when not playing or muted
      always_ff @(posedge clk) begin
        if (rst) tone_ch_reg <= SILENCE_HZ;
        else if (state_reg == ST_PLAY && !ch_mute[gi]) tone_ch_reg <= rom_hz;
        else tone_ch_reg <= SILENCE_HZ;
      end

      assign tone[32*gi +: 32] = tone_ch_reg;
    end
  endgenerate

  assign beat_num = beat_reg;
  assign playing  = playing_reg;
  assign done     = done_reg;

endmodule
